fifo_block_serializer: RTL and testbench

//  Read side of the 128-bit block FIFO (fifo_buffer). Pops one block when the FIFO is non-empty.

---
 rtl/fifo_ser_pkg.sv | 28 ++
 rtl/fifo_block_serializer.sv | 85 ++++++++
 tb/tb_fifo_block_serializer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO block serializer.
// WORDS and IDX_W describe the default 128-bit block / 32-bit word geometry.
package fifo_ser_pkg;

  localparam int unsigned BLOCK_W_DEF = 128;
  localparam int unsigned WORD_W_DEF  = 32;
  localparam int unsigned WORDS       = BLOCK_W_DEF / WORD_W_DEF;
  localparam int unsigned IDX_W       = $clog2(WORDS);

  // IDLE must encode as zero so the reset state reads back as all-zero.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } ser_state_t;

  // Reverse the byte order within one output word.
  function automatic logic [WORD_W_DEF-1:0] byte_swap(input logic [WORD_W_DEF-1:0] w);
    logic [WORD_W_DEF-1:0] r;
    r = '0;
    for (int b = 0; b < int'(WORD_W_DEF / 8); b++) begin
      r[8*b +: 8] = w[WORD_W_DEF-8-8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_block_serializer.sv
// Read side of the block FIFO: pops one block, streams it out MSW-first as
// WORD_W-bit words on a valid/ready interface, and counts completed blocks.
// Optional feature: define FIFO_SER_BYTE_SWAP_EN to byte-reverse each output word.
module fifo_block_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               fifo_empty,
  output logic               fifo_read,
  input  logic [BLOCK_W-1:0] fifo_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_sent
);

  ser_state_t         state_q;
  logic [BLOCK_W-1:0] shreg_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic [CNT_W-1:0]   blocks_q;
  logic               last_word;
  logic [WORD_W-1:0]  head_word;

  assign last_word = (word_idx_q == IDX_W'(WORDS - 1));
  assign head_word = shreg_q[BLOCK_W-1 -: WORD_W];

  // FSM, shift register, word index and block counter share one state process.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      word_idx_q <= '0;
      blocks_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= POP;
        end
        POP: begin
          // fifo_data becomes valid after this edge.
          state_q <= LOAD;
        end
        LOAD: begin
          shreg_q    <= fifo_data;
          word_idx_q <= '0;
          state_q    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            shreg_q    <= shreg_q << WORD_W;
            word_idx_q <= word_idx_q + IDX_W'(1);
            if (last_word) begin
              blocks_q <= blocks_q + CNT_W'(1);
              // Chain straight into the next pop when more data is queued.
              state_q  <= fifo_empty ? IDLE : POP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they reset with it.
  always_comb begin
    fifo_read   = (state_q == POP);
    out_valid   = (state_q == SEND);
    out_last    = (state_q == SEND) && last_word;
    busy        = (state_q != IDLE);
    blocks_sent = blocks_q;
`ifdef FIFO_SER_BYTE_SWAP_EN
    out_data    = byte_swap(head_word);
`else
    out_data    = head_word;
`endif
  end

endmodule

// File: tb/tb_fifo_block_serializer.sv
// Directed bench for fifo_block_serializer with a FIFO model and a word scoreboard.
module tb_fifo_block_serializer;

  localparam int unsigned BW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read;
  logic [BW-1:0] fifo_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] blocks_sent;

  always #5 clk = ~clk;

  fifo_block_serializer #(
    .BLOCK_W(BW),
    .WORD_W (WW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .blocks_sent(blocks_sent)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [BW-1:0] fifo_q[$];
  logic [WW:0]   exp_q[$];
  int            pop_cyc[$];

  logic          hold_v = 1'b0;
  logic [WW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_word(input logic [BW-1:0] blk, input int i);
    logic [WW-1:0] w;
    w = blk[BW-1-WW*i -: WW];
`ifdef FIFO_SER_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [BW-1:0] blk);
    fifo_q.push_back(blk);
    fifo_empty = 1'b0;
    for (int i = 0; i < int'(NW); i++) begin
      exp_q.push_back({(i == int'(NW) - 1), exp_word(blk, i)});
    end
  endtask

  // FIFO model: pop on the edge that samples fifo_read, data valid afterwards.
  always @(posedge clk) begin
    cyc++;
    if (nRst && fifo_read) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      check("no_underflow_pop", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Output monitor: scoreboard on accepted words, stability while stalled.
  always @(negedge clk) begin
    logic [WW:0] e;
    if (!nRst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_data_stable", out_data, hold_data);
        check("stall_last_stable", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("word_data", out_data, e[WW-1:0]);
          check("word_last", out_last, e[WW]);
        end
        acc_cnt++;
      end
      hold_v    = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  initial begin
    logic [BW-1:0] b1;
    int base_acc;
    int base_pop;
    int k;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    b1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    // Reset state while nRst is held low.
    #2;
    check("rst_fifo_read", fifo_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_blocks_sent", blocks_sent, 0);
    tick();
    nRst = 1'b1;

    // Test 1: empty FIFO keeps the block idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_fifo_read", fifo_read, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
    end
    check("idle_blocks_sent", blocks_sent, 0);

    // Test 2: single block, ready held high, 3-edge latency.
    out_ready = 1'b1;
    push_block(b1);
    tick();
    check("t2_pop", fifo_read, 1);
    check("t2_busy", busy, 1);
    check("t2_no_valid_pop", out_valid, 0);
    tick();
    check("t2_load_no_read", fifo_read, 0);
    check("t2_no_valid_load", out_valid, 0);
    tick();
    check("t2_first_valid", out_valid, 1);
    check("t2_word0", out_data, exp_word(b1, 0));
    check("t2_word0_last", out_last, 0);
    tick();
    check("t2_word1", out_data, exp_word(b1, 1));
    tick();
    check("t2_word2", out_data, exp_word(b1, 2));
    tick();
    check("t2_word3", out_data, exp_word(b1, 3));
    check("t2_word3_last", out_last, 1);
    tick();
    check("t2_done_valid", out_valid, 0);
    check("t2_done_busy", busy, 0);
    check("t2_blocks_sent", blocks_sent, 1);
    check("t2_acc", acc_cnt, 4);
    check("t2_sb_empty", exp_q.size() == 0, 1);

    // Test 3: two queued blocks stream back-to-back.
    base_acc = acc_cnt;
    base_pop = pop_cnt;
    push_block(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    push_block(128'h01020304_05060708_090A0B0C_0D0E0F10);
    k = 0;
    while ((blocks_sent != 3'd3) && (k < 40)) begin
      tick();
      k++;
    end
    check("t3_blocks_sent", blocks_sent, 3);
    check("t3_pops", pop_cnt - base_pop, 2);
    check("t3_pop_spacing", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], NW + 2);
    check("t3_acc", acc_cnt - base_acc, 8);
    check("t3_sb_empty", exp_q.size() == 0, 1);

    // Test 4: backpressure with ready pattern 1,0,0,1.
    base_acc = acc_cnt;
    push_block(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    k = 0;
    while ((acc_cnt < base_acc + 4) && (k < 80)) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    out_ready = 1'b1;
    tick();
    check("t4_acc", acc_cnt - base_acc, 4);
    check("t4_blocks_sent", blocks_sent, 4);
    check("t4_sb_empty", exp_q.size() == 0, 1);

    // Test 5: reset after two words, partial block discarded.
    base_acc = acc_cnt;
    push_block(128'h11111111_22222222_33333333_44444444);
    k = 0;
    while ((acc_cnt < base_acc + 2) && (k < 20)) begin
      tick();
      k++;
    end
    check("t5_two_accepted", acc_cnt - base_acc, 2);
    nRst = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_read", fifo_read, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_blocks", blocks_sent, 0);
    check("t5_two_left", exp_q.size(), 2);
    exp_q.delete();
    tick();
    nRst = 1'b1;
    tick();
    base_acc = acc_cnt;
    push_block(128'h55555555_66666666_77777777_88888888);
    k = 0;
    while ((blocks_sent != 3'd1) && (k < 20)) begin
      tick();
      k++;
    end
    check("t5_blocks_after", blocks_sent, 1);
    check("t5_acc_after", acc_cnt - base_acc, 4);
    check("t5_sb_empty", exp_q.size() == 0, 1);

    // Test 7: counter wraps modulo 2^CNT_W.
    base_acc = acc_cnt;
    for (int i = 0; i < 7; i++) begin
      push_block({$urandom, $urandom, $urandom, $urandom});
    end
    k = 0;
    while (((exp_q.size() != 0) || busy) && (k < 100)) begin
      tick();
      k++;
    end
    check("t7_wrap", blocks_sent, 0);
    check("t7_acc", acc_cnt - base_acc, 28);
    check("t7_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
